// File: rtl/painterengine_gpu_dispatcher_pkg.sv
// Shared definitions for the GPU task dispatcher and its engines:
// dispatcher state codes and the engine state-word conventions.
package painterengine_gpu_dispatcher_pkg;

  typedef enum logic [7:0] {
    StIdle       = 8'h00,
    StRun        = 8'h01,
    StDone       = 8'h02,
    StErrOpcode  = 8'h03,
    StErrEngine  = 8'h04,
    StErrTimeout = 8'h05,
    StErrAbort   = 8'h06
  } disp_state_e;

  localparam logic [7:0] EngineDoneCode  = 8'h08;
  localparam logic [7:0] EngineErrorBase = 8'h09;

  function automatic logic [31:0] pack_status(input logic [7:0] snap, input logic [7:0] opcode,
                                              input disp_state_e state);
    return {8'h00, snap, opcode, state};
  endfunction

endpackage

// File: rtl/painterengine_gpu_dma_mux.sv
// Routes the shared FIFO and DMA reader/writer to the selected engine and fans DMA
// status back to that engine only; everything reads as zero while disabled.
module painterengine_gpu_dma_mux #(
  parameter int unsigned NUM_ENGINES = 4,
  parameter int unsigned SEL_W       = 2
) (
  input  logic                       i_wire_enable,
  input  logic [SEL_W-1:0]           i_wire_select,
  input  logic [NUM_ENGINES-1:0]     i_wire_engine_fifo_resetn,
  input  logic [NUM_ENGINES-1:0]     i_wire_engine_dma_reader_resetn,
  input  logic [NUM_ENGINES-1:0]     i_wire_engine_dma_writer_resetn,
  input  logic [32*NUM_ENGINES-1:0]  i_wire_engine_dma_reader_address,
  input  logic [32*NUM_ENGINES-1:0]  i_wire_engine_dma_reader_length,
  input  logic [32*NUM_ENGINES-1:0]  i_wire_engine_dma_writer_address,
  input  logic [32*NUM_ENGINES-1:0]  i_wire_engine_dma_writer_length,
  output logic [NUM_ENGINES-1:0]     o_wire_engine_dma_reader_done,
  output logic [NUM_ENGINES-1:0]     o_wire_engine_dma_reader_error,
  output logic [NUM_ENGINES-1:0]     o_wire_engine_dma_writer_done,
  output logic [NUM_ENGINES-1:0]     o_wire_engine_dma_writer_error,
  output logic                       o_wire_fifo_resetn,
  output logic                       o_wire_dma_reader_resetn,
  output logic                       o_wire_dma_writer_resetn,
  output logic [31:0]                o_wire_dma_reader_address,
  output logic [31:0]                o_wire_dma_reader_length,
  output logic [31:0]                o_wire_dma_writer_address,
  output logic [31:0]                o_wire_dma_writer_length,
  input  logic                       i_wire_dma_reader_done,
  input  logic                       i_wire_dma_reader_error,
  input  logic                       i_wire_dma_writer_done,
  input  logic                       i_wire_dma_writer_error
);

  logic [SEL_W+4:0] base;
  assign base = {i_wire_select, 5'd0};

  always_comb begin
    o_wire_engine_dma_reader_done  = '0;
    o_wire_engine_dma_reader_error = '0;
    o_wire_engine_dma_writer_done  = '0;
    o_wire_engine_dma_writer_error = '0;
    o_wire_fifo_resetn             = 1'b0;
    o_wire_dma_reader_resetn       = 1'b0;
    o_wire_dma_writer_resetn       = 1'b0;
    o_wire_dma_reader_address      = '0;
    o_wire_dma_reader_length       = '0;
    o_wire_dma_writer_address      = '0;
    o_wire_dma_writer_length       = '0;
    if (i_wire_enable) begin
      o_wire_fifo_resetn        = i_wire_engine_fifo_resetn[i_wire_select];
      o_wire_dma_reader_resetn  = i_wire_engine_dma_reader_resetn[i_wire_select];
      o_wire_dma_writer_resetn  = i_wire_engine_dma_writer_resetn[i_wire_select];
      o_wire_dma_reader_address = i_wire_engine_dma_reader_address[base +: 32];
      o_wire_dma_reader_length  = i_wire_engine_dma_reader_length[base +: 32];
      o_wire_dma_writer_address = i_wire_engine_dma_writer_address[base +: 32];
      o_wire_dma_writer_length  = i_wire_engine_dma_writer_length[base +: 32];
      o_wire_engine_dma_reader_done[i_wire_select]  = i_wire_dma_reader_done;
      o_wire_engine_dma_reader_error[i_wire_select] = i_wire_dma_reader_error;
      o_wire_engine_dma_writer_done[i_wire_select]  = i_wire_dma_writer_done;
      o_wire_engine_dma_writer_error[i_wire_select] = i_wire_dma_writer_error;
    end
  end

endmodule

// File: rtl/painterengine_gpu_dispatcher.sv
// GPU task dispatcher: launches one engine per start, shares the DMA/FIFO with it,
// and watches its state word, a watchdog and abort to report a terminal status.
module painterengine_gpu_dispatcher
  import painterengine_gpu_dispatcher_pkg::*;
#(
  parameter int unsigned NUM_ENGINES       = 4,
  parameter logic [7:0]  ENGINE_DONE_CODE  = EngineDoneCode,
  parameter logic [7:0]  ENGINE_ERROR_BASE = EngineErrorBase
) (
  input  logic                      i_wire_clock,
  input  logic                      i_wire_resetn,
  input  logic                      i_wire_start,
  input  logic                      i_wire_abort,
  input  logic [7:0]                i_wire_opcode,
  input  logic [31:0]               i_wire_timeout_cycles,
  output logic [NUM_ENGINES-1:0]    o_wire_engine_resetn,
  input  logic [32*NUM_ENGINES-1:0] i_wire_engine_state,
  input  logic [NUM_ENGINES-1:0]    i_wire_engine_fifo_resetn,
  input  logic [NUM_ENGINES-1:0]    i_wire_engine_dma_reader_resetn,
  input  logic [NUM_ENGINES-1:0]    i_wire_engine_dma_writer_resetn,
  input  logic [32*NUM_ENGINES-1:0] i_wire_engine_dma_reader_address,
  input  logic [32*NUM_ENGINES-1:0] i_wire_engine_dma_reader_length,
  input  logic [32*NUM_ENGINES-1:0] i_wire_engine_dma_writer_address,
  input  logic [32*NUM_ENGINES-1:0] i_wire_engine_dma_writer_length,
  output logic [NUM_ENGINES-1:0]    o_wire_engine_dma_reader_done,
  output logic [NUM_ENGINES-1:0]    o_wire_engine_dma_reader_error,
  output logic [NUM_ENGINES-1:0]    o_wire_engine_dma_writer_done,
  output logic [NUM_ENGINES-1:0]    o_wire_engine_dma_writer_error,
  output logic                      o_wire_fifo_resetn,
  output logic                      o_wire_dma_reader_resetn,
  output logic                      o_wire_dma_writer_resetn,
  output logic [31:0]               o_wire_dma_reader_address,
  output logic [31:0]               o_wire_dma_reader_length,
  output logic [31:0]               o_wire_dma_writer_address,
  output logic [31:0]               o_wire_dma_writer_length,
  input  logic                      i_wire_dma_reader_done,
  input  logic                      i_wire_dma_reader_error,
  input  logic                      i_wire_dma_writer_done,
  input  logic                      i_wire_dma_writer_error,
  output logic                      o_wire_busy,
  output logic                      o_wire_irq,
  output logic [31:0]               o_wire_state
);

  localparam int unsigned SelW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

  disp_state_e state_q, state_d;
  logic [7:0]  opcode_q, opcode_d;
  logic [7:0]  snap_q, snap_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic [SelW-1:0] sel;
  logic [SelW+4:0] sel_base;
  logic [7:0]      eng_s;
  logic            run;
  logic            unused_engine_state;

  // Only valid opcodes ever reach RUN, so the low bits are the engine index.
  assign sel      = opcode_q[SelW-1:0];
  assign sel_base = {sel, 5'd0};
  assign eng_s    = i_wire_engine_state[sel_base +: 8];
  assign run      = (state_q == StRun);
  assign unused_engine_state = ^i_wire_engine_state;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    snap_d   = snap_q;
    count_d  = count_q;
    irq_d    = 1'b0;
    if (run) begin
      if (eng_s >= ENGINE_ERROR_BASE) begin
        state_d = StErrEngine;
      end else if (eng_s == ENGINE_DONE_CODE) begin
        state_d = StDone;
      end else if (i_wire_abort) begin
        state_d = StErrAbort;
      end else if ((i_wire_timeout_cycles != 32'd0) &&
                   (count_q == i_wire_timeout_cycles - 32'd1)) begin
        state_d = StErrTimeout;
      end else if (count_q != 32'hFFFF_FFFF) begin
        count_d = count_q + 32'd1;
      end
      if (state_d != StRun) begin
        irq_d  = 1'b1;
        snap_d = eng_s;
      end
    end else if (i_wire_start) begin
      opcode_d = i_wire_opcode;
      snap_d   = 8'h00;
      count_d  = 32'd0;
      if (32'(i_wire_opcode) < NUM_ENGINES) begin
        state_d = StRun;
      end else begin
        state_d = StErrOpcode;
        irq_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge i_wire_clock or negedge i_wire_resetn) begin
    if (!i_wire_resetn) begin
      state_q  <= StIdle;
      opcode_q <= 8'h00;
      snap_q   <= 8'h00;
      count_q  <= 32'd0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      snap_q   <= snap_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    o_wire_engine_resetn = '0;
    if (run) o_wire_engine_resetn[sel] = 1'b1;
  end

  assign o_wire_busy  = run;
  assign o_wire_irq   = irq_q;
  assign o_wire_state = pack_status(snap_q, opcode_q, state_q);

  painterengine_gpu_dma_mux #(
    .NUM_ENGINES(NUM_ENGINES),
    .SEL_W      (SelW)
  ) u_dma_mux (
    .i_wire_enable                    (run),
    .i_wire_select                    (sel),
    .i_wire_engine_fifo_resetn        (i_wire_engine_fifo_resetn),
    .i_wire_engine_dma_reader_resetn  (i_wire_engine_dma_reader_resetn),
    .i_wire_engine_dma_writer_resetn  (i_wire_engine_dma_writer_resetn),
    .i_wire_engine_dma_reader_address (i_wire_engine_dma_reader_address),
    .i_wire_engine_dma_reader_length  (i_wire_engine_dma_reader_length),
    .i_wire_engine_dma_writer_address (i_wire_engine_dma_writer_address),
    .i_wire_engine_dma_writer_length  (i_wire_engine_dma_writer_length),
    .o_wire_engine_dma_reader_done    (o_wire_engine_dma_reader_done),
    .o_wire_engine_dma_reader_error   (o_wire_engine_dma_reader_error),
    .o_wire_engine_dma_writer_done    (o_wire_engine_dma_writer_done),
    .o_wire_engine_dma_writer_error   (o_wire_engine_dma_writer_error),
    .o_wire_fifo_resetn               (o_wire_fifo_resetn),
    .o_wire_dma_reader_resetn         (o_wire_dma_reader_resetn),
    .o_wire_dma_writer_resetn         (o_wire_dma_writer_resetn),
    .o_wire_dma_reader_address        (o_wire_dma_reader_address),
    .o_wire_dma_reader_length         (o_wire_dma_reader_length),
    .o_wire_dma_writer_address        (o_wire_dma_writer_address),
    .o_wire_dma_writer_length         (o_wire_dma_writer_length),
    .i_wire_dma_reader_done           (i_wire_dma_reader_done),
    .i_wire_dma_reader_error          (i_wire_dma_reader_error),
    .i_wire_dma_writer_done           (i_wire_dma_writer_done),
    .i_wire_dma_writer_error          (i_wire_dma_writer_error)
  );

endmodule
